vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing generator, successor to the fixed 640x480 controller. It sits between the clock generator and the pixel colour generator. It produces the pixel row/column coordinates and the sync and blanking signals. Timing, sync polarity and clock-enable stepping are configurable, and sync/active outputs are delayed so they stay aligned with a colour pipeline of known latency. It also emits line-start and frame-start strobes for frame-synchronous logic such as generation updates.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_POL, 0, hSync asserted level (0 = active-low)
- V_POL, 0, vSync asserted level
- PIPE_DELAY, 2, pixel steps of delay on hSync/vSync/displayActive; legal range 1..8
- COL_W, 10, column width; must satisfy 2^COL_W >= H_ACTIVE+H_FRONT+H_SYNC+H_BACK
- ROW_W, 10, row width; must satisfy 2^ROW_W >= V total

Ports:
- clk  in  1  sole clock
- rstN  in  1  synchronous reset, active-low
- pixEn  in  1  pixel-step strobe; tie high for one pixel per clk
- column  out  COL_W  current horizontal count, 0..H_TOTAL-1
- row  out  ROW_W  current vertical count, 0..V_TOTAL-1
- hSync  out  1  delayed horizontal sync
- vSync  out  1  delayed vertical sync
- displayActive  out  1  delayed visible-region flag
- lineStart  out  1  one-clk pulse on a step where column wraps to 0
- frameStart  out  1  one-clk pulse on a step where column and row both wrap to 0

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK. V_TOTAL is the same sum for the V parameters.
- Counters change only on clk edges where rstN=1 and pixEn=1.
- Horizontal step: column = column+1, or 0 when column = H_TOTAL-1.
- Vertical step: row advances only when column wraps. It becomes row+1, or 0 when row = V_TOTAL-1.
- Raw decode of the current counters:
  - hs = (column >= H_ACTIVE+H_FRONT) && (column < H_ACTIVE+H_FRONT+H_SYNC)
  - vs is the same form using row and the V parameters
  - act = (column < H_ACTIVE) && (row < V_ACTIVE)
- Delay line: PIPE_DELAY stages of {hs, vs, act}, shifted only on pixEn steps.
  - hSync = H_POL when the last-stage hs is 1, else !H_POL. vSync uses V_POL the same way.
  - displayActive = last-stage act.
- lineStart and frameStart are registered pulses, high for the clk after the wrapping step, and high for exactly one clk even if pixEn stays high.
- When pixEn=0, every output except lineStart and frameStart holds its value. Those two are 0 on any clk after a non-wrapping or stalled step.

## Timing
- Reset (rstN=0 at a clk edge) forces:
  - column=0, row=0
  - every delay stage to {hs=0, vs=0, act=0}, so hSync=!H_POL, vSync=!V_POL, displayActive=0
  - lineStart=0, frameStart=0
- Reset mid-frame discards all pipeline contents; there is no partial line.
- Reset has priority over pixEn.
- Latency: hSync/vSync/displayActive reflect the counter value seen PIPE_DELAY pixEn steps earlier. The colour generator must register its colour PIPE_DELAY steps after sampling row/column.
- First pixEn step after reset: column goes 0→1, and lineStart/frameStart stay 0 because no wrap occurred.
- The first frameStart pulse occurs after H_TOTAL·V_TOTAL steps.
- A step where column = H_TOTAL-1 and row = V_TOTAL-1 wraps both counters to 0 and pulses both lineStart and frameStart on the same clk.
- Parameters are static. Illegal combinations (PIPE_DELAY=0, counter widths too small) are rejected at elaboration.

## Test plan
- Reset values: hold rstN=0 for 3 clks with pixEn=1 → column=0, row=0, hSync=1, vSync=1, displayActive=0, lineStart=0, frameStart=0 (default parameters).
- Horizontal line: default parameters, pixEn=1 → lineStart every 800 clks; hSync low for 96 clks, first low clk 656+2 steps after column=0; displayActive high for 640 clks per active line.
- Vertical frame: run 800·525 steps → frameStart exactly once per 420000 clks; vSync low during rows 490–491 (delayed 2 steps); displayActive low throughout rows 480–524.
- Stall: pixEn pulsing 1-of-4 clks → all counts and sync widths scale ×4 in clks; outputs are stable on stalled clks; lineStart is still 1 clk wide.
- Mid-frame reset: assert rstN=0 at row 200, column 300 → the next clk shows all reset values; the following frameStart comes 420000 steps after release.
- Small config: H_ACTIVE=4, H_FRONT=1, H_SYNC=2, H_BACK=1, V_ACTIVE=3, V_FRONT=1, V_SYNC=1, V_BACK=1, H_POL=1, V_POL=1, PIPE_DELAY=1 → an 8×6 frame; hSync high at column 5–6 delayed by 1 step; simultaneous lineStart/frameStart at the 48-step wrap.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Pixel-step strobe and timing outputs of vga_timing_gen.
// The master drives the timing; the slave (colour path) consumes it.
interface vga_timing_gen_if #(
    parameter int COL_W = 10,
    parameter int ROW_W = 10
);
    logic             pixEn;
    logic [COL_W-1:0] column;
    logic [ROW_W-1:0] row;
    logic             hSync;
    logic             vSync;
    logic             displayActive;
    logic             lineStart;
    logic             frameStart;

    modport master (
        input  pixEn,
        output column,
        output row,
        output hSync,
        output vSync,
        output displayActive,
        output lineStart,
        output frameStart
    );

    modport slave (
        output pixEn,
        input  column,
        input  row,
        input  hSync,
        input  vSync,
        input  displayActive,
        input  lineStart,
        input  frameStart
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel/line counters, sync decode,
// a sync/active delay line matched to the colour pipeline, line/frame strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b0,
    parameter int PIPE_DELAY = 2,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 10
) (
    input logic              clk,
    input logic              rstN,
    vga_timing_gen_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [31:0] C_H_LAST  = 32'(H_TOTAL - 1);
    localparam logic [31:0] C_V_LAST  = 32'(V_TOTAL - 1);
    localparam logic [31:0] C_H_ACT   = 32'(H_ACTIVE);
    localparam logic [31:0] C_V_ACT   = 32'(V_ACTIVE);
    localparam logic [31:0] C_HS_BEG  = 32'(H_ACTIVE + H_FRONT);
    localparam logic [31:0] C_HS_END  = 32'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [31:0] C_VS_BEG  = 32'(V_ACTIVE + V_FRONT);
    localparam logic [31:0] C_VS_END  = 32'(V_ACTIVE + V_FRONT + V_SYNC);

    // Reject configurations that cannot work at elaboration time.
    if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_delay
        $error("vga_timing_gen: PIPE_DELAY must be 1..8");
    end
    if (H_ACTIVE < 1 || H_FRONT < 0 || H_SYNC < 0 || H_BACK < 0)
    begin : g_bad_h
        $error("vga_timing_gen: illegal horizontal timing");
    end
    if (V_ACTIVE < 1 || V_FRONT < 0 || V_SYNC < 0 || V_BACK < 0)
    begin : g_bad_v
        $error("vga_timing_gen: illegal vertical timing");
    end
    if (COL_W < 1 || COL_W > 30 || (2 ** COL_W) < H_TOTAL) begin : g_bad_colw
        $error("vga_timing_gen: COL_W too small for H total");
    end
    if (ROW_W < 1 || ROW_W > 30 || (2 ** ROW_W) < V_TOTAL) begin : g_bad_roww
        $error("vga_timing_gen: ROW_W too small for V total");
    end

    logic [COL_W-1:0]            r_col;
    logic [ROW_W-1:0]            r_row;
    logic [PIPE_DELAY-1:0][2:0]  r_pipe;
    logic                        r_line;
    logic                        r_frame;

    logic [31:0] w_col32;
    logic [31:0] w_row32;
    logic        w_col_last;
    logic        w_row_last;
    logic        w_hs;
    logic        w_vs;
    logic        w_act;
    logic [2:0]  w_new;
    logic [2:0]  w_tap;

    assign w_col32    = 32'(r_col);
    assign w_row32    = 32'(r_row);
    assign w_col_last = (w_col32 == C_H_LAST);
    assign w_row_last = (w_row32 == C_V_LAST);

    // Raw sync/active decode of the current counters.
    assign w_hs  = (w_col32 >= C_HS_BEG) && (w_col32 < C_HS_END);
    assign w_vs  = (w_row32 >= C_VS_BEG) && (w_row32 < C_VS_END);
    assign w_act = (w_col32 < C_H_ACT) && (w_row32 < C_V_ACT);
    assign w_new = {w_hs, w_vs, w_act};

    // Column/row counters; the row only moves when the column wraps.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_col <= '0;
            r_row <= '0;
        end else if (bus.pixEn) begin
            if (w_col_last) begin
                r_col <= '0;
                if (w_row_last) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Delay line keeping sync/active aligned with the colour pipeline.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_pipe <= '0;
        end else if (bus.pixEn) begin
            r_pipe[0] <= w_new;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // One-clk line/frame strobes following a wrapping step.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_line  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_line  <= bus.pixEn && w_col_last;
            r_frame <= bus.pixEn && w_col_last && w_row_last;
        end
    end

    assign w_tap = r_pipe[PIPE_DELAY-1];

    assign bus.column        = r_col;
    assign bus.row           = r_row;
    assign bus.hSync         = w_tap[2] ? H_POL : ~H_POL;
    assign bus.vSync         = w_tap[1] ? V_POL : ~V_POL;
    assign bus.displayActive = w_tap[0];
    assign bus.lineStart     = r_line;
    assign bus.frameStart    = r_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations driven in lockstep and
// checked every clk against a step-count model, plus vectors and sequences.
module tb_vga_timing_gen;

    typedef struct {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit hp; bit vp; int d;
    } cfg_t;

    typedef struct {
        int col; int row;
        bit hsync; bit vsync; bit act; bit ls; bit fs;
    } exp_t;

    typedef struct {
        bit r; bit p;
        int col; int row;
        bit hsync; bit vsync; bit act; bit ls; bit fs;
    } vec_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic pix = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.COL_W(10), .ROW_W(10)) bus_a ();
    vga_timing_gen_if #(.COL_W(3),  .ROW_W(3))  bus_b ();
    vga_timing_gen_if #(.COL_W(5),  .ROW_W(5))  bus_c ();

    assign bus_a.pixEn = pix;
    assign bus_b.pixEn = pix;
    assign bus_c.pixEn = pix;

    vga_timing_gen u_a (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(1),
        .COL_W(3), .ROW_W(3)
    ) u_b (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(5),
        .V_ACTIVE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .H_POL(1'b0), .V_POL(1'b1), .PIPE_DELAY(8),
        .COL_W(5), .ROW_W(5)
    ) u_c (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus_c)
    );

    cfg_t   CA, CB, CC;
    longint n = 0;
    bit     st = 1'b0;
    bit     armed = 1'b0;
    int     tests = 0;
    int     failed = 0;

    function automatic exp_t model(cfg_t c, longint k, bit stepped);
        exp_t   e;
        int     ht, vt, cc, rr;
        longint m;
        bit     h, v, a;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        e.col = int'(k % ht);
        e.row = int'((k / ht) % vt);
        e.ls  = stepped && (k > 0) && ((k % ht) == 0);
        e.fs  = stepped && (k > 0) && ((k % (ht * vt)) == 0);
        h = 1'b0; v = 1'b0; a = 1'b0;
        if (k >= c.d) begin
            m  = k - c.d;
            cc = int'(m % ht);
            rr = int'((m / ht) % vt);
            h  = (cc >= c.ha + c.hf) && (cc < c.ha + c.hf + c.hs);
            v  = (rr >= c.va + c.vf) && (rr < c.va + c.vf + c.vs);
            a  = (cc < c.ha) && (rr < c.va);
        end
        e.hsync = h ? c.hp : !c.hp;
        e.vsync = v ? c.vp : !c.vp;
        e.act   = a;
        return e;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            failed++;
            if (failed <= 40)
                $display("FAIL %s: got %0d, want %0d (step %0d)",
                         nm, got, want, n);
        end
    endtask

    task automatic chk_bus(input string p, input exp_t e,
                           input int col, input int row,
                           input bit hs, input bit vs, input bit act,
                           input bit ls, input bit fs);
        chk({p, ".column"}, col, e.col);
        chk({p, ".row"}, row, e.row);
        chk({p, ".hSync"}, int'(hs), int'(e.hsync));
        chk({p, ".vSync"}, int'(vs), int'(e.vsync));
        chk({p, ".displayActive"}, int'(act), int'(e.act));
        chk({p, ".lineStart"}, int'(ls), int'(e.ls));
        chk({p, ".frameStart"}, int'(fs), int'(e.fs));
    endtask

    task automatic check_all();
        chk_bus("A", model(CA, n, st), int'(bus_a.column), int'(bus_a.row),
                bus_a.hSync, bus_a.vSync, bus_a.displayActive,
                bus_a.lineStart, bus_a.frameStart);
        chk_bus("B", model(CB, n, st), int'(bus_b.column), int'(bus_b.row),
                bus_b.hSync, bus_b.vSync, bus_b.displayActive,
                bus_b.lineStart, bus_b.frameStart);
        chk_bus("C", model(CC, n, st), int'(bus_c.column), int'(bus_c.row),
                bus_c.hSync, bus_c.vSync, bus_c.displayActive,
                bus_c.lineStart, bus_c.frameStart);
    endtask

    task automatic cyc(input bit r, input bit p);
        rstN = r;
        pix  = p;
        @(posedge clk);
        if (!r) begin
            n = 0; st = 1'b0; armed = 1'b1;
        end else if (p) begin
            n++; st = 1'b1;
        end else begin
            st = 1'b0;
        end
        #1;
        if (armed) check_all();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vt[14];
        int   lows, acts, lss, first_low;

        CA = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2};
        CB = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 1};
        CC = '{20, 2, 3, 5, 10, 2, 2, 3, 1'b0, 1'b1, 8};

        //         r  p  col row hs vs act ls fs   (small config B)
        vt[0]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{1, 1, 1, 0, 0, 0, 1, 0, 0};
        vt[3]  = '{1, 0, 1, 0, 0, 0, 1, 0, 0};
        vt[4]  = '{1, 1, 2, 0, 0, 0, 1, 0, 0};
        vt[5]  = '{1, 1, 3, 0, 0, 0, 1, 0, 0};
        vt[6]  = '{1, 1, 4, 0, 0, 0, 1, 0, 0};
        vt[7]  = '{1, 1, 5, 0, 0, 0, 0, 0, 0};
        vt[8]  = '{1, 1, 6, 0, 1, 0, 0, 0, 0};
        vt[9]  = '{1, 1, 7, 0, 1, 0, 0, 0, 0};
        vt[10] = '{1, 1, 0, 1, 0, 0, 0, 1, 0};
        vt[11] = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
        vt[12] = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
        vt[13] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 14; i++) begin
            cyc(vt[i].r, vt[i].p);
            chk($sformatf("vec%0d.column", i), int'(bus_b.column), vt[i].col);
            chk($sformatf("vec%0d.row", i), int'(bus_b.row), vt[i].row);
            chk($sformatf("vec%0d.hSync", i), int'(bus_b.hSync), int'(vt[i].hsync));
            chk($sformatf("vec%0d.vSync", i), int'(bus_b.vSync), int'(vt[i].vsync));
            chk($sformatf("vec%0d.act", i), int'(bus_b.displayActive), int'(vt[i].act));
            chk($sformatf("vec%0d.lineStart", i), int'(bus_b.lineStart), int'(vt[i].ls));
            chk($sformatf("vec%0d.frameStart", i), int'(bus_b.frameStart), int'(vt[i].fs));
        end

        // Reset held 3 clks with pixEn high: default-config reset values.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        chk("rst.A.column", int'(bus_a.column), 0);
        chk("rst.A.row", int'(bus_a.row), 0);
        chk("rst.A.hSync", int'(bus_a.hSync), 1);
        chk("rst.A.vSync", int'(bus_a.vSync), 1);
        chk("rst.A.act", int'(bus_a.displayActive), 0);
        chk("rst.A.lineStart", int'(bus_a.lineStart), 0);
        chk("rst.A.frameStart", int'(bus_a.frameStart), 0);

        // Small config: simultaneous strobes on the 48-step wrap.
        for (int i = 0; i < 47; i++) cyc(1'b1, 1'b1);
        chk("wrap47.B.column", int'(bus_b.column), 7);
        chk("wrap47.B.row", int'(bus_b.row), 5);
        chk("wrap47.B.frameStart", int'(bus_b.frameStart), 0);
        cyc(1'b1, 1'b1);
        chk("wrap48.B.column", int'(bus_b.column), 0);
        chk("wrap48.B.row", int'(bus_b.row), 0);
        chk("wrap48.B.lineStart", int'(bus_b.lineStart), 1);
        chk("wrap48.B.frameStart", int'(bus_b.frameStart), 1);
        cyc(1'b1, 1'b1);
        chk("wrap49.B.lineStart", int'(bus_b.lineStart), 0);
        chk("wrap49.B.frameStart", int'(bus_b.frameStart), 0);

        // Default config, pixEn 1-of-4: widths scale by 4 in clks.
        cyc(1'b0, 1'b0);
        lows = 0; acts = 0; lss = 0; first_low = -1;
        for (int k = 0; k < 3200; k++) begin
            cyc(1'b1, (k % 4) == 0);
            if (!bus_a.hSync) begin
                lows++;
                if (first_low < 0) first_low = k;
            end
            if (bus_a.displayActive) acts++;
            if (bus_a.lineStart) lss++;
        end
        chk("stall.hsync_low_clks", lows, 384);
        chk("stall.first_low_clk", first_low, 2628);
        chk("stall.active_clks", acts, 2560);
        chk("stall.linestart_clks", lss, 1);

        // Mid-line reset, then a full medium frame from release.
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        chk("midrst.A.column", int'(bus_a.column), 0);
        chk("midrst.A.hSync", int'(bus_a.hSync), 1);
        chk("midrst.C.vSync", int'(bus_c.vSync), 0);
        for (int i = 0; i < 509; i++) cyc(1'b1, 1'b1);
        chk("frame509.C.frameStart", int'(bus_c.frameStart), 0);
        cyc(1'b1, 1'b1);
        chk("frame510.C.frameStart", int'(bus_c.frameStart), 1);
        chk("frame510.C.row", int'(bus_c.row), 0);

        // Randomised stalls and occasional resets against the model.
        for (int k = 0; k < 6000; k++) begin
            cyc(($urandom % 1500) != 0, ($urandom % 10) < 7);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
